softmax_sched: RTL

Round-robin scheduler that shares one `softmax_approx` datapath (64 × Q6.10 lanes, 1024-bit flat bus, length modes 0..5) between `NUM_REQ` requesters, such as per-head attention engines. Each accepted request is tagged with its requester ID in an in-order tag FIFO. Results are routed back to the originating requester. When the destination is not ready, the scheduler freezes the whole softmax pipeline through its `i_en` input.

---
 rtl/softmax_sched_pkg.sv | 15 +
 rtl/sched_tag_fifo.sv | 47 ++++
 rtl/softmax_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/softmax_sched_pkg.sv
// Shared constants, tag type and mode check for the softmax request scheduler.
package softmax_sched_pkg;
    localparam int DATA_W      = 1024;
    localparam int MODE_W      = 4;
    localparam int MAX_MODE    = 5;
    // Tag is sized for the largest supported requester count.
    localparam int NUM_REQ_MAX = 4;
    localparam int TAG_W       = $clog2(NUM_REQ_MAX);

    typedef logic [TAG_W-1:0] sm_tag_t;

    function automatic logic mode_legal(input int mode, input int max_mode);
        return mode <= max_mode;
    endfunction
endpackage

// File: rtl/sched_tag_fifo.sv
// In-order FIFO of requester tags for results still inside the softmax pipeline.
module sched_tag_fifo
    import softmax_sched_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  sm_tag_t          push_tag,
    input  logic             pop,
    output sm_tag_t          head,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    sm_tag_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

    // A full FIFO that pops this cycle may still push: the slot frees at the same edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/softmax_sched.sv
// Round-robin arbiter sharing one softmax datapath between requesters, with
// tag-based in-order response routing and whole-pipeline freeze on backpressure.
module softmax_sched #(
    parameter int  NUM_REQ   = 2,
    parameter int  DATA_W    = softmax_sched_pkg::DATA_W,
    parameter int  MODE_W    = softmax_sched_pkg::MODE_W,
    parameter int  MAX_MODE  = softmax_sched_pkg::MAX_MODE,
    parameter int  TAG_DEPTH = 8,
    localparam int CNT_W     = $clog2(TAG_DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic [NUM_REQ*MODE_W-1:0] i_req_mode,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_x_flat,
    output logic                      o_sm_en,
    output logic                      o_sm_valid,
    output logic [MODE_W-1:0]         o_sm_length_mode,
    output logic [DATA_W-1:0]         o_sm_x_flat,
    input  logic                      i_sm_valid,
    input  logic [DATA_W-1:0]         i_sm_prob_flat,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic [DATA_W-1:0]         o_rsp_prob_flat,
    output logic [CNT_W-1:0]          o_inflight,
    output logic                      o_err_mode,
    output logic                      o_err_orphan
);
    import softmax_sched_pkg::*;

    sm_tag_t           head_id, win_id, last_grant;
    logic [CNT_W-1:0]  tag_cnt;
    logic              fifo_ne, head_rdy, stall, pop, room, found, grant, legal, push;
    logic [MODE_W-1:0] win_mode;
    logic [DATA_W-1:0] win_x;
    int                best;

    assign fifo_ne = (tag_cnt != '0);

    always_comb begin
        head_rdy    = 1'b0;
        o_rsp_valid = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (head_id == sm_tag_t'(k)) begin
                head_rdy       = i_rsp_ready[k];
                o_rsp_valid[k] = i_sm_valid & fifo_ne;
            end
        end
    end

    // An orphan result has no owner, so it never holds the pipeline.
    assign stall   = i_sm_valid & fifo_ne & ~head_rdy;
    assign o_sm_en = i_en & ~stall & ~i_rst;
    assign pop     = i_sm_valid & fifo_ne & head_rdy;
    assign room    = (tag_cnt < CNT_W'(TAG_DEPTH)) | pop;

    // Winner is the valid requester at the smallest rotated distance past last_grant.
    always_comb begin
        best     = NUM_REQ;
        win_id   = last_grant;
        win_mode = '0;
        win_x    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req_valid[k] &&
                ((k + 2*NUM_REQ - int'(last_grant) - 1) % NUM_REQ) < best) begin
                best     = (k + 2*NUM_REQ - int'(last_grant) - 1) % NUM_REQ;
                win_id   = sm_tag_t'(k);
                win_mode = i_req_mode[k*MODE_W +: MODE_W];
                win_x    = i_req_x_flat[k*DATA_W +: DATA_W];
            end
        end
    end

    assign found = (best < NUM_REQ);
    assign grant = o_sm_en & room & found;
    assign legal = mode_legal(int'(win_mode), MAX_MODE);
    assign push  = grant & legal;

    always_comb begin
        o_req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++)
            o_req_ready[k] = grant & (win_id == sm_tag_t'(k));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sm_valid       <= 1'b0;
            o_sm_length_mode <= '0;
            o_sm_x_flat      <= '0;
            o_err_mode       <= 1'b0;
            o_err_orphan     <= 1'b0;
            last_grant       <= sm_tag_t'(NUM_REQ - 1);
        end else begin
            o_err_mode <= grant & ~legal;
            if (i_sm_valid & ~fifo_ne) o_err_orphan <= 1'b1;
            if (grant) last_grant <= win_id;
            if (o_sm_en) begin
                o_sm_valid <= push;
                if (push) begin
                    o_sm_length_mode <= win_mode;
                    o_sm_x_flat      <= win_x;
                end
            end
        end
    end

    sched_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (push),
        .push_tag (win_id),
        .pop      (pop),
        .head     (head_id),
        .count    (tag_cnt)
    );

    assign o_rsp_prob_flat = i_sm_prob_flat;
    assign o_inflight      = tag_cnt;
endmodule
